// File: rtl/alu_ctrl_pkg.sv
// Shared control definitions for the ALU sequencer: opcodes, FSM states,
// instruction classes and alu_sel bit positions.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_ROR  = 5'b00100;
    localparam logic [4:0] OP_ROL  = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // alu_sel is one-hot; these are its bit positions.
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_AND   = 2;
    localparam int ALU_OR    = 3;
    localparam int ALU_SHR   = 4;
    localparam int ALU_SHRA  = 5;
    localparam int ALU_SHL   = 6;
    localparam int ALU_ROR   = 7;
    localparam int ALU_ROL   = 8;
    localparam int ALU_NEG   = 9;
    localparam int ALU_NOT   = 10;
    localparam int ALU_MUL   = 11;
    localparam int ALU_DIV   = 12;
    localparam int ALU_INCPC = 13;
    localparam int ALU_W     = 14;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_BINARY, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
    } op_class_t;

    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-strobe bundle between the ALU sequencer (master)
// and the datapath it controls (slave).
interface alu_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [13:0] alu_sel;

    modport master (
        input  start, ir,
        output busy, done, illegal, Rin, Rout, alu_sel,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin
    );

    modport slave (
        output start, ir,
        input  busy, done, illegal, Rin, Rout, alu_sel,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin
    );
endinterface

// File: rtl/ir_decoder.sv
// Combinational IR decode: instruction class, one-hot ALU operation and
// one-hot register selects for the Ra/Rb/Rc fields.
module ir_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [31:0]      ir,
    output op_class_t        op_class,
    output logic [ALU_W-1:0] alu_onehot,
    output logic [15:0]      ra_sel,
    output logic [15:0]      rb_sel,
    output logic [15:0]      rc_sel
);

    // NOTE: defaults first so every path assigns every output; no latch.
    always_comb begin
        op_class   = CLS_ILLEGAL;
        alu_onehot = '0;
        case (ir[31:27])
            OP_ADD:  begin op_class = CLS_BINARY; alu_onehot[ALU_ADD]  = 1'b1; end
            OP_SUB:  begin op_class = CLS_BINARY; alu_onehot[ALU_SUB]  = 1'b1; end
            OP_AND:  begin op_class = CLS_BINARY; alu_onehot[ALU_AND]  = 1'b1; end
            OP_OR:   begin op_class = CLS_BINARY; alu_onehot[ALU_OR]   = 1'b1; end
            OP_ROR:  begin op_class = CLS_BINARY; alu_onehot[ALU_ROR]  = 1'b1; end
            OP_ROL:  begin op_class = CLS_BINARY; alu_onehot[ALU_ROL]  = 1'b1; end
            OP_SHR:  begin op_class = CLS_BINARY; alu_onehot[ALU_SHR]  = 1'b1; end
            OP_SHRA: begin op_class = CLS_BINARY; alu_onehot[ALU_SHRA] = 1'b1; end
            OP_SHL:  begin op_class = CLS_BINARY; alu_onehot[ALU_SHL]  = 1'b1; end
            OP_NEG:  begin op_class = CLS_UNARY;  alu_onehot[ALU_NEG]  = 1'b1; end
            OP_NOT:  begin op_class = CLS_UNARY;  alu_onehot[ALU_NOT]  = 1'b1; end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_onehot[ALU_MUL]  = 1'b1; end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_onehot[ALU_DIV]  = 1'b1; end
            default: begin op_class = CLS_ILLEGAL; alu_onehot = '0; end
        endcase
    end

    assign ra_sel = reg_onehot(ir[26:23]);
    assign rb_sel = reg_onehot(ir[22:19]);
    assign rc_sel = reg_onehot(ir[18:15]);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer: walks IDLE, T0..T6, DONE and drives the
// datapath strobes for one instruction per start request.
module alu_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    alu_sequencer_if.master bus
);

    state_t           state;
    op_class_t        op_class;
    logic [ALU_W-1:0] alu_onehot;
    logic [15:0]      ra_sel, rb_sel, rc_sel;

    ir_decoder u_dec (
        .ir         (bus.ir),
        .op_class   (op_class),
        .alu_onehot (alu_onehot),
        .ra_sel     (ra_sel),
        .rb_sel     (rb_sel),
        .rc_sel     (rc_sel)
    );

    // NOTE: state is sequential, so it is updated with <= only.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3:    state <= (op_class == CLS_ILLEGAL) ? S_DONE : S_T4;
                S_T4:    state <= (op_class == CLS_UNARY)   ? S_DONE : S_T5;
                S_T5:    state <= (op_class == CLS_BINARY)  ? S_DONE : S_T6;
                S_T6:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state and ir so strobes line up with the
    // state they belong to, with no extra cycle of delay.
    always_comb begin
        bus.busy     = (state != S_IDLE) && (state != S_DONE);
        bus.done     = (state == S_DONE);
        bus.illegal  = (state == S_DONE) && (op_class == CLS_ILLEGAL);
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.alu_sel  = '0;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                bus.alu_sel[ALU_INCPC] = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_BINARY: begin bus.Rout = rb_sel; bus.Yin = 1'b1; end
                    CLS_MULDIV: begin bus.Rout = ra_sel; bus.Yin = 1'b1; end
                    CLS_UNARY:  begin bus.Rout = rb_sel; bus.alu_sel = alu_onehot; bus.Zin = 1'b1; end
                    default:    ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_BINARY: begin bus.Rout = rc_sel; bus.alu_sel = alu_onehot; bus.Zin = 1'b1; end
                    CLS_MULDIV: begin bus.Rout = rb_sel; bus.alu_sel = alu_onehot; bus.Zin = 1'b1; end
                    CLS_UNARY:  begin bus.Zlowout = 1'b1; bus.Rin = ra_sel; end
                    default:    ;
                endcase
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (op_class == CLS_MULDIV) bus.LOin = 1'b1;
                else                        bus.Rin  = ra_sel;
            end
            S_T6: begin
                bus.Zhighout = 1'b1; bus.HIin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against a table-driven
// model of the per-cycle control word of each instruction class.
module tb_alu_sequencer;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Strobe masks within the 14-bit strobe field of the packed control word.
    localparam logic [13:0] M_PCOUT = 14'h2000, M_PCIN  = 14'h1000, M_INCPC = 14'h0800;
    localparam logic [13:0] M_MARIN = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100;
    localparam logic [13:0] M_READ  = 14'h0080, M_IRIN  = 14'h0040, M_YIN   = 14'h0020;
    localparam logic [13:0] M_ZIN   = 14'h0010, M_ZLO   = 14'h0008, M_ZHI   = 14'h0004;
    localparam logic [13:0] M_HIIN  = 14'h0002, M_LOIN  = 14'h0001;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    int          exp_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe();
        return {1'b0, bus.busy, bus.done, bus.illegal,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.Read,
                bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin,
                bus.Rin, bus.Rout, bus.alu_sel};
    endfunction

    function automatic logic [63:0] mk(input logic busy, input logic done, input logic ill,
                                       input logic [13:0] str, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [13:0] alu);
        return {1'b0, busy, done, ill, str, rin, rout, alu};
    endfunction

    // Builds the expected control word for every cycle from T0 to DONE.
    function automatic void model(input logic [31:0] ir_v);
        logic [4:0]  opc;
        int          alu_idx;
        int          cls;   // 0 binary, 1 unary, 2 mul/div, 3 illegal
        logic [13:0] op;
        logic [15:0] one, ra_h, rb_h, rc_h;
        opc = ir_v[31:27];
        cls = 0;
        alu_idx = 0;
        case (opc)
            5'd0:  alu_idx = 0;
            5'd1:  alu_idx = 1;
            5'd2:  alu_idx = 2;
            5'd3:  alu_idx = 3;
            5'd4:  alu_idx = 7;
            5'd5:  alu_idx = 8;
            5'd6:  alu_idx = 4;
            5'd7:  alu_idx = 5;
            5'd8:  alu_idx = 6;
            5'd17: begin cls = 1; alu_idx = 9;  end
            5'd18: begin cls = 1; alu_idx = 10; end
            5'd15: begin cls = 2; alu_idx = 11; end
            5'd16: begin cls = 2; alu_idx = 12; end
            default: cls = 3;
        endcase
        op   = (cls == 3) ? 14'd0 : (14'd1 << alu_idx);
        one  = 16'd1;
        ra_h = one << ir_v[26:23];
        rb_h = one << ir_v[22:19];
        rc_h = one << ir_v[18:15];
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 0, 14'h2000));
        exp_q.push_back(mk(1, 0, 0, M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, M_MDROUT | M_IRIN, 0, 0, 0));
        case (cls)
            0: begin
                exp_q.push_back(mk(1, 0, 0, M_YIN, 0, rb_h, 0));
                exp_q.push_back(mk(1, 0, 0, M_ZIN, 0, rc_h, op));
                exp_q.push_back(mk(1, 0, 0, M_ZLO, ra_h, 0, 0));
                exp_lat = 7;
            end
            1: begin
                exp_q.push_back(mk(1, 0, 0, M_ZIN, 0, rb_h, op));
                exp_q.push_back(mk(1, 0, 0, M_ZLO, ra_h, 0, 0));
                exp_lat = 6;
            end
            2: begin
                exp_q.push_back(mk(1, 0, 0, M_YIN, 0, ra_h, 0));
                exp_q.push_back(mk(1, 0, 0, M_ZIN, 0, rb_h, op));
                exp_q.push_back(mk(1, 0, 0, M_ZLO | M_LOIN, 0, 0, 0));
                exp_q.push_back(mk(1, 0, 0, M_ZHI | M_HIIN, 0, 0, 0));
                exp_lat = 8;
            end
            default: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                exp_lat = 5;
            end
        endcase
        exp_q.push_back(mk(0, 1, (cls == 3), 0, 0, 0, 0));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one instruction from IDLE and checks every cycle through the
    // IDLE cycle that follows DONE.
    task automatic run_instr(input logic [31:0] ir_v, input string name, input bit hold_start);
        int seen;
        int n;
        seen = -1;
        model(ir_v);
        n = exp_q.size();
        bus.ir    = ir_v;
        bus.start = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s cyc%0d", name, i), observe(), exp_q[i]);
            if (bus.done === 1'b1 && seen < 0) seen = i + 1;
            bus.start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        check($sformatf("%s latency", name), 64'(seen), 64'(exp_lat));
        check($sformatf("%s idle after done", name), observe(), 64'd0);
    endtask

    logic [31:0] rnd;
    logic [4:0]  legal_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                    5'd7, 5'd8, 5'd15, 5'd16, 5'd17, 5'd18};

    initial begin
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.ir    = 32'd0;
        repeat (3) step();
        check("reset state", observe(), 64'd0);

        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle no start", observe(), 64'd0);
        end

        // clear has priority over start
        clear     = 1'b1;
        bus.start = 1'b1;
        step();
        check("clear beats start", observe(), 64'd0);
        clear     = 1'b0;
        bus.start = 1'b0;
        step();

        run_instr(32'h112B0000, "AND R2,R5,R6", 1'b0);
        run_instr(32'h81880000, "DIV R3,R1", 1'b0);
        run_instr(32'h8A380000, "NEG R4,R7", 1'b0);
        run_instr(32'hF8000000, "illegal 11111", 1'b0);

        // Abort an ADD in T4: back to IDLE with no done pulse.
        model(32'h00912000);
        bus.ir    = 32'h00912000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort ADD cyc%0d", i), observe(), exp_q[i]);
            if (i < 4) step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort idle", observe(), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort no done", observe(), 64'd0);
        end

        // start held high: one IDLE cycle between instructions
        run_instr(32'h112B0000, "b2b AND", 1'b1);
        run_instr(32'h7C000000, "b2b MUL", 1'b1);
        run_instr(32'h90000000, "b2b NOT", 1'b1);
        bus.start = 1'b0;
        step();

        for (int k = 0; k < 60; k++) begin
            rnd = $urandom();
            if ($urandom_range(0, 4) == 0) rnd[31:27] = 5'($urandom_range(0, 31));
            else                           rnd[31:27] = legal_ops[$urandom_range(0, 12)];
            run_instr(rnd, $sformatf("rnd%0d ir=%h", k, rnd), 1'b0);
            bus.start = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                step();
                check("rnd idle gap", observe(), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
